// File: rtl/alu4bit_pkg.sv
// Shared types and constants for the 4-bit ALU and its request arbiter.
package alu4bit_pkg;

    localparam int DATA_W = 4;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 2'b00;
    localparam alu_op_t OP_SUB = 2'b01;
    localparam alu_op_t OP_AND = 2'b10;
    localparam alu_op_t OP_OR  = 2'b11;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu4bit_core.sv
// Combinational 4-bit ALU: ADD/SUB with carry/borrow, AND, OR.
module alu4bit_core
    import alu4bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // The extra top bit of a zero-extended subtract is exactly the borrow (a < b).
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu4bit_share_arbiter.sv
// Round-robin sharing of one 4-bit ALU among N_REQ requesters, with a
// single-entry response buffer tagged by requester ID.
module alu4bit_share_arbiter
    import alu4bit_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    input  logic [2*N_REQ-1:0]      req_op,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_carry,
    input  logic                    rsp_ready
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic [N_REQ-1:0]  grant;
    logic              slot_free;
    logic              accept;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    alu_op_t           op_sel;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    buf_state_t        state;

    assign rsp_valid = (state == BUF_FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    // N_REQ is a power of two, so ID_W-bit addition wraps the search modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
        grant           = '0;
        grant[grant_id] = found;
    end

    assign req_ready = (slot_free && !rst) ? grant : '0;
    assign accept    = |req_ready;

    assign a_sel  = req_a[DATA_W*grant_id +: DATA_W];
    assign b_sel  = req_b[DATA_W*grant_id +: DATA_W];
    assign op_sel = req_op[2*grant_id +: 2];

    alu4bit_core u_core (
        .a      (a_sel),
        .b      (b_sel),
        .op     (op_sel),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // Response buffer: accept takes priority over drain, so a drain+accept stays FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BUF_EMPTY;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                state     <= BUF_FULL;
                rsp_id    <= grant_id;
                rsp_data  <= alu_res;
                rsp_carry <= alu_carry;
                ptr       <= grant_id + ID_W'(1);
            end else if (rsp_valid && rsp_ready) begin
                state <= BUF_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu4bit_share_arbiter.sv
// Directed bench for alu4bit_share_arbiter: reset, arithmetic, fairness, backpressure.
module tb_alu4bit_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_op;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        rsp_carry;
    logic        rsp_ready;

    int n_cmp = 0;
    int n_bad = 0;

    alu4bit_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] op);
        req_valid[i]     = v;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_op[2*i +: 2] = op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        set_req(2, 1'b1, 4'd15, 4'd15, 2'b11);
        step();
        req_valid = '0;
        // buffer now FULL with 15 from requester 2; scramble inputs, then reset mid-cycle
        req_valid = 4'($urandom_range(1, 15));
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 8'($urandom);
        rsp_ready = 1'($urandom);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id got %0h want 0", rsp_id); end
        n_cmp++; if (rsp_data !== 4'd0) begin n_bad++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
        n_cmp++; if (rsp_carry !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_carry got %0h want 0", rsp_carry); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %0h want 0", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        set_req(2, 1'b1, 4'd4, 4'd1, 2'b00);
        set_req(3, 1'b1, 4'd9, 4'd2, 2'b10);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL reset_first_grant got %0h want 4", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL reset_first_id got %0h want 2", rsp_id); end
        n_cmp++; if (rsp_data !== 4'd5) begin n_bad++; $display("FAIL reset_first_data got %0h want 5", rsp_data); end
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd3, 4'd5, 2'b00);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL add_req_ready got %0h want 1", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_rsp_valid got %0h want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL add_rsp_id got %0h want 0", rsp_id); end
        n_cmp++; if (rsp_data !== 4'd8) begin n_bad++; $display("FAIL add_rsp_data got %0h want 8", rsp_data); end
        n_cmp++; if (rsp_carry !== 1'b0) begin n_bad++; $display("FAIL add_rsp_carry got %0h want 0", rsp_carry); end
    endtask

    task automatic test_arith();
        logic [1:0] ops [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [3:0] as  [6] = '{4'd9, 4'd2, 4'd7, 4'd12, 4'd12, 4'd15};
        logic [3:0] bs  [6] = '{4'd9, 4'd5, 4'd7, 4'd10, 4'd3,  4'd1};
        logic [3:0] eds [6] = '{4'd2, 4'd13, 4'd0, 4'd8, 4'd15, 4'd0};
        logic       ecs [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            set_req(3, 1'b1, as[t], bs[t], ops[t]);
            step();
            req_valid = '0;
            n_cmp++; if (rsp_id !== 2'd3) begin n_bad++; $display("FAIL arith%0d_id got %0h want 3", t, rsp_id); end
            n_cmp++; if (rsp_data !== eds[t]) begin n_bad++; $display("FAIL arith%0d_data got %0h want %0h", t, rsp_data, eds[t]); end
            n_cmp++; if (rsp_carry !== ecs[t]) begin n_bad++; $display("FAIL arith%0d_carry got %0h want %0h", t, rsp_carry, ecs[t]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_id [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i), 4'd1, 2'b00);
        for (int t = 0; t < 6; t++) begin
            step();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rr%0d_valid got %0h want 1", t, rsp_valid); end
            n_cmp++; if (rsp_id !== exp_id[t]) begin n_bad++; $display("FAIL rr%0d_id got %0h want %0h", t, rsp_id, exp_id[t]); end
            n_cmp++; if (rsp_data !== 4'(exp_id[t]) + 4'd1) begin n_bad++; $display("FAIL rr%0d_data got %0h want %0h", t, rsp_data, 4'(exp_id[t]) + 4'd1); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 4'd6, 4'd3, 2'b01);
        for (int t = 0; t < 3; t++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp%0d_req_ready got %0h want 0", t, req_ready); end
            step();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d_valid got %0h want 1", t, rsp_valid); end
            n_cmp++; if (rsp_id !== 2'd1) begin n_bad++; $display("FAIL bp%0d_id got %0h want 1", t, rsp_id); end
            n_cmp++; if (rsp_data !== 4'd2) begin n_bad++; $display("FAIL bp%0d_data got %0h want 2", t, rsp_data); end
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_release_ready got %0h want 4", req_ready); end
        step();
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_new_valid got %0h want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL bp_new_id got %0h want 2", rsp_id); end
        n_cmp++; if (rsp_data !== 4'd3) begin n_bad++; $display("FAIL bp_new_data got %0h want 3", rsp_data); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 4'd1, 4'd1, 2'b00);
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        // buffer FULL (id 1), ptr = 2
        set_req(1, 1'b1, 4'd5, 4'd4, 2'b11);
        set_req(3, 1'b1, 4'd8, 4'd9, 2'b00);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid got %0h want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 4'd0) begin n_bad++; $display("FAIL mid_rsp_data got %0h want 0", rsp_data); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_req_ready got %0h want 0", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_grant got %0h want 2", req_ready); end
        step();
        req_valid[1] = 1'b0;
        n_cmp++; if (rsp_id !== 2'd1) begin n_bad++; $display("FAIL mid_first_id got %0h want 1", rsp_id); end
        n_cmp++; if (rsp_data !== 4'd5) begin n_bad++; $display("FAIL mid_first_data got %0h want 5", rsp_data); end
        step();
        req_valid = '0;
        n_cmp++; if (rsp_id !== 2'd3) begin n_bad++; $display("FAIL mid_second_id got %0h want 3", rsp_id); end
        n_cmp++; if (rsp_data !== 4'd1 || rsp_carry !== 1'b1) begin n_bad++; $display("FAIL mid_second_result got %0h/%0h want 1/1", rsp_data, rsp_carry); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu4bit_share_arbiter.md
# alu4bit_share_arbiter

Shares one 4-bit ALU among `N_REQ` requesters. Each requester presents operands and an opcode on a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the result is registered into a single-entry response buffer tagged with the requester ID. The block sits between the request sources and the combinational 4-bit ALU core, which it instantiates. It provides fair, back-pressured access to that core.

## Interface
- `N_REQ`, default 4: number of requesters; must be a power of two, minimum 2.
- `ID_W`, default 2: requester ID width; equals log2(`N_REQ`).
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`: bit i high means requester i has a request.
- `req_a`  in  4*`N_REQ`: operand A; requester i uses bits [4i+3:4i].
- `req_b`  in  4*`N_REQ`: operand B; same packing as `req_a`.
- `req_op`  in  2*`N_REQ`: opcode; requester i uses bits [2i+1:2i].
- `req_ready`  out  `N_REQ`: one-hot or zero; bit i high means requester i's request is accepted this cycle.
- `rsp_valid`  out  1: response buffer holds a result.
- `rsp_id`  out  `ID_W`: requester that owns the result.
- `rsp_data`  out  4: ALU result.
- `rsp_carry`  out  1: carry (ADD) or borrow (SUB); 0 for logic ops.
- `rsp_ready`  in  1: consumer accepts the response.

## Operation
- **Opcodes:**
  - 00 ADD: {carry, data} = a + b.
  - 01 SUB: data = (a − b) mod 16; carry = 1 iff a < b.
  - 10 AND.
  - 11 OR.
- **Slot free:** `slot_free` = !`rsp_valid` || `rsp_ready`. A response drained in a cycle frees the slot in that same cycle.
- **Arbitration:** combinational round-robin over `req_valid`, starting at pointer `ptr`.
  - Grant the first valid index at or after `ptr`, modulo `N_REQ`.
  - `req_ready` equals that grant one-hot when `slot_free`, otherwise all zeros.
- **Handshake rule:** `req_ready` depends on `req_valid`. A requester must not derive `req_valid` from `req_ready`. Once asserted, `req_valid` and its operands stay stable until accepted.
- **Accept (rising edge with some `req_ready[i]` high):**
  - Operands of requester i pass through the ALU core.
  - `rsp_data`, `rsp_carry` and `rsp_id` = i are registered, and `rsp_valid` is set to 1.
  - `ptr` becomes (i+1) mod `N_REQ`.
- **Drain without accept:** on an edge with `rsp_valid` && `rsp_ready` and no grant, `rsp_valid` goes to 0. Data, ID and carry hold their last values.
- **Hold:** while `rsp_valid` && !`rsp_ready`, all response outputs are frozen and `ptr` is unchanged.
- **No request:** when no request is valid, `ptr` is unchanged.
- **Buffer state:** two states, EMPTY and FULL.
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on drain with accept.
- **Reset (asynchronous, effective immediately, including mid-transfer):**
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_carry`=0, `ptr`=0.
  - An in-flight response is discarded.
  - `req_ready` is combinational: while `rst` is high it is all zeros.

## Timing
- Latency: an accept at edge N gives `rsp_valid`=1 with the result in the cycle after edge N.
- Throughput: one result per cycle while `rsp_ready`=1.
- No combinational path from `req_*` to any `rsp_*` output.
- Combinational paths exist from `req_valid` and `rsp_ready` to `req_ready`.
- Starvation bound: a continuously valid requester is granted within `N_REQ` accepts.

## Structure
- **Package `alu4bit_pkg`:**
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`;
  - `alu_op_t` (2-bit);
  - `DATA_W` = 4.
- **Sub-module `alu4bit_core`:** purely combinational; inputs a, b, op; outputs 4-bit result and carry.
- The arbiter, pointer, and response register live in the top module.

## Test plan
- **Reset:** assert `rst` mid-cycle with random inputs → all outputs 0 immediately; after release, the first grant goes to the lowest valid index.
- **Single ADD:** requester 0, a=3, b=5, ADD, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_data`=8, `rsp_carry`=0.
- **Arithmetic corners:**
  - ADD 9+9 → data 2, carry 1.
  - SUB 2−5 → data 13, carry 1.
  - SUB 7−7 → data 0, carry 0.
  - AND 12,10 → 8.
  - OR 12,3 → 15.
- **Fairness:** all four requesters continuously valid, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1; one result per cycle.
- **Backpressure:** hold `rsp_ready`=0 with buffer FULL for 3 cycles → `req_ready`=0 and `rsp_*` unchanged. Then raise `rsp_ready` → drain and the next grant happen on the same edge, and the new result appears the following cycle.
- **Reset mid-operation:** `rst` pulsed while `rsp_valid`=1 and `ptr`=2 → `rsp_valid` drops at once. After release, with requesters 1 and 3 valid, requester 1 is granted first (`ptr` reset to 0).
